// File: rtl/clk_enable_nco_pkg.sv
// Shared definitions for the clk_enable_nco clock-enable generator.
//   nco_state_t : settle/run state of the lock FSM
//   ACC_W_DEF   : default phase accumulator width
//   calc_inc()  : elaboration-time helper turning a reference/output frequency
//                 pair into a phase increment for an acc_w-bit accumulator
package clk_enable_nco_pkg;

    typedef enum logic {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } nco_state_t;

    localparam int ACC_W_DEF = 32;

    // inc = round(f_out * 2^acc_w / f_ref). The real-to-integer cast rounds to
    // nearest, which is the rounding we want here.
    function automatic longint unsigned calc_inc(input real f_ref_hz,
                                                 input real f_out_hz,
                                                 input int  acc_w);
        real scaled;
        scaled = f_out_hz * (2.0 ** acc_w) / f_ref_hz;
        return longint'(scaled);
    endfunction

endpackage

// File: rtl/clk_enable_nco_channel.sv
// One phase-accumulator channel of the clock-enable generator.
// Ports:
//   clk     : fabric clock (rising edge)
//   clr     : synchronous clear of accumulator, enable pulse and divided strobe
//   en      : advance the accumulator by inc this edge
//   inc     : phase increment
//   ce      : one-cycle enable, registered carry of the accumulator add
//   clk_div : toggles on every ce (half the ce rate, 50% duty)
module nco_channel
    import clk_enable_nco_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [ACC_W-1:0] inc,
    output logic             ce,
    output logic             clk_div
);

    logic [ACC_W-1:0] acc_p0;
    logic [ACC_W:0]   sum_p0;
    logic             carry_p1;
    logic             div_p1;

    assign sum_p0 = {1'b0, acc_p0} + {1'b0, inc};

    // stage p0 -> p1: accumulate, register carry as the enable pulse
    always_ff @(posedge clk) begin
        if (clr) begin
            acc_p0   <= '0;
            carry_p1 <= 1'b0;
            div_p1   <= 1'b0;
        end else if (en) begin
            acc_p0   <= sum_p0[ACC_W-1:0];
            carry_p1 <= sum_p0[ACC_W];
            if (sum_p0[ACC_W]) begin
                div_p1 <= ~div_p1;
            end
        end else begin
            carry_p1 <= 1'b0;
        end
    end

    assign ce      = carry_p1;
    assign clk_div = div_p1;

endmodule

// File: rtl/clk_enable_nco.sv
// Multi-channel fractional clock-enable generator with PLL-like lock output.
// Each channel runs a phase accumulator; its overflow gives a one-cycle ce
// pulse and toggles a 50%-duty clk_div. Increments are written into shadow
// registers through a valid/ready port and applied to all channels at once by
// cfg_commit, which also re-aligns every phase and re-runs the settle period.
// Ports:
//   refclk     : sole clock, rising edge
//   rst_n      : synchronous active-low reset
//   cfg_valid  : config write request
//   cfg_ready  : config port can accept (high only while locked)
//   cfg_chan   : target channel of the write
//   cfg_inc    : new increment, lands in the shadow register
//   cfg_commit : apply all shadows and restart phases (ignored while settling)
//   cfg_err    : one-cycle pulse after a write to a channel >= NUM_CH
//   ce         : per-channel one-cycle enable pulses
//   clk_div    : per-channel divided strobes, toggling on each ce
//   locked     : outputs valid and phase-aligned
module clk_enable_nco
    import clk_enable_nco_pkg::*;
#(
    parameter int                      NUM_CH      = 2,
    parameter int                      ACC_W       = ACC_W_DEF,
    parameter int                      LOCK_CYCLES = 16,
    parameter logic [NUM_CH*ACC_W-1:0] INC_INIT    = {NUM_CH{32'd614961148}},
    localparam int                     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_chan,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic              cfg_commit,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] clk_div,
    output logic              locked
);

    localparam int                CNT_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    nco_state_t       state;
    logic [CNT_W-1:0] settle_cnt;
    logic [ACC_W-1:0] shadow     [NUM_CH];
    logic [ACC_W-1:0] shadow_nxt [NUM_CH];
    logic [ACC_W-1:0] active     [NUM_CH];
    logic             wr_fire;
    logic             chan_ok;
    logic             commit_fire;
    logic             ch_en;
    logic             ch_clr;

    assign wr_fire     = cfg_valid && cfg_ready;
    assign chan_ok     = (int'(cfg_chan) < NUM_CH);
    assign commit_fire = cfg_commit && (state == RUN);

    // Channels only accumulate in RUN; a commit clears them on the same edge
    // so the next settle starts from acc = 0 on every channel.
    assign ch_en  = (state == RUN) && !commit_fire;
    assign ch_clr = !rst_n || !ch_en;

    // A write on the commit edge is folded in first so the commit applies it.
    always_comb begin
        shadow_nxt = shadow;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_fire && chan_ok && (cfg_chan == CH_W'(c))) begin
                shadow_nxt[c] = cfg_inc;
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            locked     <= 1'b0;
            cfg_ready  <= 1'b0;
            cfg_err    <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                shadow[c] <= INC_INIT[c*ACC_W +: ACC_W];
                active[c] <= INC_INIT[c*ACC_W +: ACC_W];
            end
        end else begin
            shadow  <= shadow_nxt;
            cfg_err <= wr_fire && !chan_ok;
            case (state)
                SETTLE: begin
                    if (settle_cnt == CNT_LAST) begin
                        state      <= RUN;
                        settle_cnt <= '0;
                        locked     <= 1'b1;
                        cfg_ready  <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (cfg_commit) begin
                        active     <= shadow_nxt;
                        state      <= SETTLE;
                        settle_cnt <= '0;
                        locked     <= 1'b0;
                        cfg_ready  <= 1'b0;
                    end
                end
                default: begin
                    state <= SETTLE;
                end
            endcase
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        nco_channel #(
            .ACC_W (ACC_W)
        ) u_ch (
            .clk     (refclk),
            .clr     (ch_clr),
            .en      (ch_en),
            .inc     (active[c]),
            .ce      (ce[c]),
            .clk_div (clk_div[c])
        );
    end

endmodule

// File: tb/tb_clk_enable_nco.sv
// Scoreboard bench for clk_enable_nco (ACC_W=8, LOCK_CYCLES=4).
// Stimulus pushes expected ce cycle numbers per channel; a negedge monitor pops
// them as pulses appear and tracks the expected clk_div level.
module tb_clk_enable_nco;

    logic       refclk;
    logic       rst_n;
    logic       cfg_valid, cfg_ready, cfg_commit, cfg_err, locked;
    logic [0:0] cfg_chan;
    logic [7:0] cfg_inc;
    logic [1:0] ce, clk_div;

    logic       cfg_valid3, cfg_ready3, cfg_commit3, cfg_err3, locked3;
    logic [1:0] cfg_chan3;
    logic [7:0] cfg_inc3;
    logic [2:0] ce3, clk_div3;

    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    int  base   = 0;
    int  win_end = -1;
    int  exp_q [2][$];
    logic [1:0] exp_div = '0;

    clk_enable_nco #(
        .NUM_CH(2), .ACC_W(8), .LOCK_CYCLES(4), .INC_INIT({8'd128, 8'd64})
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan), .cfg_inc(cfg_inc), .cfg_commit(cfg_commit),
        .cfg_err(cfg_err), .ce(ce), .clk_div(clk_div), .locked(locked)
    );

    clk_enable_nco #(
        .NUM_CH(3), .ACC_W(8), .LOCK_CYCLES(4), .INC_INIT({8'd32, 8'd128, 8'd64})
    ) dut3 (
        .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
        .cfg_chan(cfg_chan3), .cfg_inc(cfg_inc3), .cfg_commit(cfg_commit3),
        .cfg_err(cfg_err3), .ce(ce3), .clk_div(clk_div3), .locked(locked3)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;
    always @(posedge refclk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every pulse must match the head of its channel queue.
    always @(negedge refclk) begin
        if (cyc <= win_end) begin
            for (int c = 0; c < 2; c++) begin
                while (exp_q[c].size() > 0 && exp_q[c][0] < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL ce%0d_missing actual=none required=cycle %0d", c, exp_q[c][0]);
                    void'(exp_q[c].pop_front());
                end
                if (ce[c]) begin
                    checks++;
                    if (exp_q[c].size() == 0 || exp_q[c][0] != cyc) begin
                        errors++;
                        $display("FAIL ce%0d_unexpected actual=cycle %0d required=cycle %0d", c, cyc,
                                 (exp_q[c].size() > 0) ? exp_q[c][0] : -1);
                    end else begin
                        void'(exp_q[c].pop_front());
                        exp_div[c] = ~exp_div[c];
                    end
                end
                check($sformatf("clk_div%0d", c), int'(clk_div[c]), int'(exp_div[c]));
            end
        end
    end

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic open_window(input int len);
        exp_q[0].delete();
        exp_q[1].delete();
        exp_div = '0;
        win_end = base + len;
    endtask

    task automatic push_per(input int c, input int first, input int period);
        for (int t = base + first; t <= win_end; t += period) exp_q[c].push_back(t);
    endtask

    task automatic end_window();
        while (cyc < win_end) tick();
        @(negedge refclk);
        #1;
        check("ce0_queue_left", exp_q[0].size(), 0);
        check("ce1_queue_left", exp_q[1].size(), 0);
    endtask

    task automatic write(input logic [0:0] ch, input logic [7:0] inc);
        cfg_valid = 1'b1;
        cfg_chan  = ch;
        cfg_inc   = inc;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        base = cyc;
    endtask

    // Called just after the reset/commit edge: four cycles unlocked, then locked.
    task automatic settle_check(input bit inject_commit);
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) tick();
            if (inject_commit) cfg_commit = (i == 2);
            check($sformatf("locked_settle%0d", i), int'(locked), (i == 4) ? 1 : 0);
            check($sformatf("cfg_ready_settle%0d", i), int'(cfg_ready), (i == 4) ? 1 : 0);
        end
        cfg_commit = 1'b0;
    endtask

    initial begin
        int n0, n1, n2;
        rst_n = 1'b0;
        cfg_valid = 1'b0; cfg_chan = '0; cfg_inc = '0; cfg_commit = 1'b0;
        cfg_valid3 = 1'b0; cfg_chan3 = '0; cfg_inc3 = '0; cfg_commit3 = 1'b0;

        // Reset state
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_locked", int'(locked), 0);
            check("rst_cfg_ready", int'(cfg_ready), 0);
            check("rst_ce", int'(ce), 0);
            check("rst_clk_div", int'(clk_div), 0);
            check("rst_cfg_err", int'(cfg_err), 0);
            check("rst3_div", int'(clk_div3), 0);
        end
        rst_n = 1'b1;
        base = cyc;
        open_window(40);
        push_per(0, 8, 4);
        push_per(1, 6, 2);
        settle_check(1'b0);
        // Shadow-only write: ch0 must keep its old rate inside this window.
        while (cyc < base + 20) tick();
        write(1'b0, 8'd3);
        end_window();

        // Fractional rate: ch0 inc=3 overflows on adds 86, 171, 256
        do_commit();
        open_window(264);
        exp_q[0].push_back(base + 90);
        exp_q[0].push_back(base + 175);
        exp_q[0].push_back(base + 260);
        push_per(1, 6, 2);
        settle_check(1'b0);
        end_window();

        // Commit timing and phase restart: ch1=32, ch0 back to 64
        write(1'b1, 8'd32);
        write(1'b0, 8'd64);
        do_commit();
        open_window(60);
        push_per(0, 8, 4);
        push_per(1, 12, 8);
        settle_check(1'b0);
        end_window();

        // Write and commit on the same edge: ch0=16 takes effect
        cfg_valid = 1'b1; cfg_chan = 1'b0; cfg_inc = 8'd16; cfg_commit = 1'b1;
        tick();
        cfg_valid = 1'b0; cfg_commit = 1'b0;
        base = cyc;
        open_window(60);
        push_per(0, 20, 16);
        push_per(1, 12, 8);
        settle_check(1'b0);
        end_window();

        // Reset in the middle of a settle: shadows revert, settle runs in full
        write(1'b0, 8'd16);
        do_commit();
        tick();
        tick();
        check("mid_settle_locked", int'(locked), 0);
        rst_n = 1'b0;
        tick();
        check("mid_rst_locked", int'(locked), 0);
        rst_n = 1'b1;
        base = cyc;
        cfg_valid = 1'b1; cfg_chan = 1'b1; cfg_inc = 8'd64;
        open_window(40);
        push_per(0, 8, 4);
        push_per(1, 6, 2);
        settle_check(1'b0);
        tick();
        cfg_valid = 1'b0;
        end_window();

        // Write held through settle landed on the first RUN edge; commit in
        // SETTLE is ignored.
        do_commit();
        open_window(40);
        push_per(0, 8, 4);
        push_per(1, 8, 4);
        settle_check(1'b1);
        end_window();

        // Out-of-range channel on the three-channel build
        tick();
        check("err3_idle", int'(cfg_err3), 0);
        cfg_valid3 = 1'b1; cfg_chan3 = 2'd3; cfg_inc3 = 8'd200;
        tick();
        cfg_valid3 = 1'b0;
        check("err3_pulse", int'(cfg_err3), 1);
        check("err3_locked", int'(locked3), 1);
        tick();
        check("err3_clear", int'(cfg_err3), 0);
        check("err3_locked_after", int'(locked3), 1);
        cfg_commit3 = 1'b1;
        tick();
        cfg_commit3 = 1'b0;
        n0 = 0; n1 = 0; n2 = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            n0 += int'(ce3[0]);
            n1 += int'(ce3[1]);
            n2 += int'(ce3[2]);
        end
        check("ch3_0_pulses", n0, 9);
        check("ch3_1_pulses", n1, 18);
        check("ch3_2_pulses", n2, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
